timer_bus_master: RTL and testbench

//  Initiator side of the peripheral req/we/addr/data bus used by timer and other CSR-mapped blocks.
//  - Accepts read/write commands from the core through a small command FIFO.
//  - Drives one bus transaction at a time and collects grant and read data.
//  - Returns exactly one response per command, with an error flag on timeout.

---
 rtl/timer_bus_master.sv | 184 ++++++++++++++++++
 tb/tb_timer_bus_master.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bus_master.sv
// Peripheral bus initiator: buffers core commands in a small FIFO, runs one req/gnt/rvalid
// transaction at a time and returns one response per command, flagging timeouts as errors.
module timer_bus_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  req_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StResp} state_e;

    // Command FIFO storage
    logic                  fifo_we    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic                  push, pop;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    // Full blocks a push even when a pop happens in the same cycle.
    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_we[wr_ptr_q]    <= cmd_we;
            fifo_addr[wr_ptr_q]  <= cmd_addr;
            fifo_wdata[wr_ptr_q] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    we_d    = fifo_we[rd_ptr_q];
                    addr_d  = fifo_addr[rd_ptr_q];
                    wdata_d = fifo_wdata[rd_ptr_q];
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                // A grant on the last allowed cycle still completes normally.
                if (gnt_i) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                        state_d     = StResp;
                    end else begin
                        state_d = StWaitR;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitR: begin
                if (rvalid_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rdata_i;
                    rsp_err_d   = 1'b0;
                    state_d     = StResp;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_o     = req_q;
    assign we_o      = we_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_timer_bus_master.sv
// Directed bench for timer_bus_master: a transaction-level model predicts bus fields, request
// lengths and responses per command; a bus responder plays back per-command grant/data timing.
module tb_timer_bus_master;

    localparam int TO = 16;
    localparam int FD = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;    // grant in this req cycle (0 = first), <0 never
        int          rd;    // rvalid this many cycles after grant, <1 never
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        req_o, we_o, gnt_i, rvalid_i;
    logic [31:0] addr_o, wdata_o, rdata_i;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    timer_bus_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(FD),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .req_o    (req_o),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .gnt_i    (gnt_i),
        .rvalid_i (rvalid_i),
        .rdata_i  (rdata_i),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    cmd_t tb_cmd;
    cmd_t iss_q[$];
    rsp_t rsp_q[$];
    int   occ = 0;
    bit   mon_en = 0;
    bit   stray = 0;
    int   rsp_cnt = 0;
    int   last_req_len = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not expected by model at %0t", name, $time);
    endtask

    function automatic bit gnt_timeout(input cmd_t c);
        return (c.gd < 0) || (c.gd > TO - 1);
    endfunction

    function automatic int exp_len(input cmd_t c);
        return gnt_timeout(c) ? TO : c.gd + 1;
    endfunction

    function automatic rsp_t exp_rsp(input cmd_t c);
        rsp_t r;
        r.rdata = '0;
        r.err   = 1'b0;
        if (gnt_timeout(c)) r.err = 1'b1;
        else if (!c.we) begin
            if (c.rd < 1 || c.rd > TO) r.err = 1'b1;
            else r.rdata = c.rdata;
        end
        return r;
    endfunction

    // Monitor / scoreboard, sampled mid-cycle.
    cmd_t cur;
    bit   have_cur = 0;
    bit   prev_req = 0;
    int   req_len = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            iss_q.delete();
            rsp_q.delete();
            occ      = 0;
            have_cur = 0;
            prev_req = 0;
        end else begin
            if (req_o) begin
                if (!prev_req) begin
                    if (iss_q.size() == 0) fail_now("req_unexpected");
                    else begin
                        cur      = iss_q.pop_front();
                        occ--;
                        have_cur = 1;
                        req_len  = 0;
                    end
                end
                req_len++;
                if (have_cur)
                    chk("bus_fields", {we_o, addr_o, cur.we ? wdata_o : 32'h0},
                        {cur.we, cur.addr, cur.we ? cur.wdata : 32'h0});
            end else if (prev_req && have_cur) begin
                chk("req_len", req_len, exp_len(cur));
                last_req_len = req_len;
                have_cur     = 0;
            end
            prev_req = req_o;
            chk("cmd_ready", cmd_ready, occ < FD);
            if (rsp_valid) begin
                if (rsp_q.size() == 0) fail_now("rsp_unexpected");
                else begin
                    chk("rsp", {rsp_err, rsp_rdata}, {rsp_q[0].err, rsp_q[0].rdata});
                    if (rsp_ready) begin
                        void'(rsp_q.pop_front());
                        rsp_cnt++;
                        last_rdata = rsp_rdata;
                        last_err   = rsp_err;
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                iss_q.push_back(tb_cmd);
                rsp_q.push_back(exp_rsp(tb_cmd));
                occ++;
            end
        end
    end

    // Bus responder: replays grant/data timing of the command at the head of the issue queue.
    int   r_ph = 0;
    int   r_cyc = 0;
    cmd_t r_cmd;
    always @(posedge clk) begin
        #2;
        gnt_i    = 1'b0;
        rvalid_i = 1'b0;
        rdata_i  = '0;
        if (!rst_n) r_ph = 0;
        else if (stray) begin
            gnt_i    = 1'b1;
            rvalid_i = 1'b1;
            rdata_i  = 32'hBAD0_BAD0;
        end else begin
            if (r_ph == 0 && req_o && iss_q.size() != 0) begin
                r_cmd = iss_q[0];
                r_cyc = 0;
                r_ph  = 1;
            end else if (r_ph != 0) r_cyc++;
            if (r_ph == 1) begin
                if (!req_o) r_ph = 0;
                else if (r_cyc == r_cmd.gd) begin
                    gnt_i = 1'b1;
                    r_ph  = r_cmd.we ? 0 : 2;
                    r_cyc = 0;
                end
            end else if (r_ph == 2) begin
                if (r_cyc == r_cmd.rd) begin
                    rvalid_i = 1'b1;
                    rdata_i  = r_cmd.rdata;
                    r_ph     = 0;
                end else if (r_cyc > TO + 1) r_ph = 0;
            end
        end
    end

    // Caller sits at posedge+1; returns at posedge+1 after the push edge.
    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int gd, input int rd, input logic [31:0] rdat);
        int n;
        tb_cmd    = '{we: we, addr: a, wdata: d, rdata: rdat, gd: gd, rd: rd};
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                fail_now("push_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (iss_q.size() == 0 && rsp_q.size() == 0 && !req_o && !have_cur) break;
            n++;
            if (n > 400) begin
                fail_now("drain_timeout");
                break;
            end
        end
        cycles(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        tb_cmd    = '{we: 1'b0, addr: '0, wdata: '0, rdata: '0, gd: 0, rd: 1};
        #12;
        chk("rst_outs", {req_o, we_o, rsp_valid, rsp_err, addr_o, wdata_o, rsp_rdata}, 96'h0);
        chk("rst_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(2);
        mon_en = 1;

        // Write, granted in its first request cycle
        push(1'b1, 32'h10, 32'h5A, 0, 0, 32'h0);
        drain();
        chk("wr_len", last_req_len, 1);
        chk("wr_rsp", {last_err, last_rdata}, {1'b0, 32'h0});
        chk("wr_cnt", rsp_cnt, 1);

        // Read, immediate grant, data 3 cycles later
        push(1'b0, 32'h14, 32'h0, 0, 3, 32'h0000_0007);
        drain();
        chk("rd_rsp", {last_err, last_rdata}, {1'b0, 32'h7});
        chk("rd_cnt", rsp_cnt, 2);

        // Three back-to-back commands with the core stalling responses
        rsp_ready = 1'b0;
        push(1'b1, 32'h20, 32'h1111, 0, 0, 32'h0);
        push(1'b0, 32'h24, 32'h0, 2, 1, 32'h1234);
        push(1'b1, 32'h28, 32'h3333, 1, 0, 32'h0);
        cycles(6);
        chk("full_ready", cmd_ready, 1'b0);
        chk("stall_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        drain();
        chk("b2b_cnt", rsp_cnt, 5);

        // No grant at all -> timeout, then stray handshakes are ignored
        push(1'b1, 32'h30, 32'hAA, -1, 0, 32'h0);
        drain();
        chk("to_len", last_req_len, 16);
        chk("to_rsp", {last_err, last_rdata}, {1'b1, 32'h0});
        stray = 1;
        cycles(3);
        stray = 0;
        cycles(3);
        chk("stray_cnt", rsp_cnt, 6);
        chk("stray_idle", {req_o, rsp_valid}, 2'b00);

        // rvalid on the last allowed wait cycle wins; one cycle later is a timeout
        push(1'b0, 32'h34, 32'h0, 1, 16, 32'hCAFE_F00D);
        drain();
        chk("rv_edge", {last_err, last_rdata}, {1'b0, 32'hCAFE_F00D});
        push(1'b0, 32'h38, 32'h0, 0, 17, 32'h5555_5555);
        drain();
        chk("rv_late", {last_err, last_rdata}, {1'b1, 32'h0});

        // Grant on the last request cycle completes; one later times out
        push(1'b1, 32'h3C, 32'h77, 15, 0, 32'h0);
        push(1'b0, 32'h40, 32'h0, 16, 1, 32'h9999);
        drain();
        chk("gnt_late", {last_err, last_rdata}, {1'b1, 32'h0});
        chk("edge_cnt", rsp_cnt, 10);

        // Reset pulsed while waiting for read data
        push(1'b0, 32'h44, 32'h0, 0, -1, 32'h0);
        cycles(4);
        mon_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {req_o, we_o, rsp_valid, rsp_err, addr_o, wdata_o, rsp_rdata}, 96'h0);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        mon_en = 1;
        cycles(20);
        chk("post_rst_cnt", rsp_cnt, 10);

        push(1'b1, 32'h48, 32'h99, 1, 0, 32'h0);
        drain();
        chk("post_rst_len", last_req_len, 2);
        chk("post_rst_rsp", {last_err, last_rdata}, {1'b0, 32'h0});
        chk("post_rst_cnt2", rsp_cnt, 11);

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
